// File: rtl/decode_issue_queue.sv
// Buffered decode stage: fetched instructions wait in a circular queue, the head is
// decoded combinationally and issued to RS or LSB (plus RoB) when the target has room.
module decode_issue_queue #(
    parameter int QUEUE_DEPTH_WIDTH = 3,
    parameter int ROB_ID_WIDTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    fetch_valid,
    input  logic [31:0]             fetch_instr,
    input  logic [31:0]             fetch_pc,
    input  logic                    fetch_pred_taken,
    output logic                    queue_full,
    input  logic                    flush,
    input  logic                    rob_full,
    input  logic                    rs_full,
    input  logic                    lsb_full,
    output logic                    issue_valid,
    output logic                    issue_to_lsb,
    output logic [31:0]             issue_instr,
    output logic [31:0]             issue_pc,
    output logic [2:0]              issue_op,
    output logic [6:0]              issue_type,
    output logic [31:0]             issue_imm,
    output logic [4:0]              issue_rd,
    output logic                    issue_pred_taken,
    output logic [4:0]              reg_id1,
    output logic [4:0]              reg_id2,
    input  logic [31:0]             reg_value1_in,
    input  logic [31:0]             reg_value2_in,
    input  logic                    has_dep1_in,
    input  logic                    has_dep2_in,
    input  logic [ROB_ID_WIDTH-1:0] v_rob_id1_in,
    input  logic [ROB_ID_WIDTH-1:0] v_rob_id2_in,
    input  logic [ROB_ID_WIDTH-1:0] rd_rob_id_in,
    output logic [31:0]             reg_value1_out,
    output logic [31:0]             reg_value2_out,
    output logic                    has_dep1_out,
    output logic                    has_dep2_out,
    output logic [ROB_ID_WIDTH-1:0] v_rob_id1_out,
    output logic [ROB_ID_WIDTH-1:0] v_rob_id2_out,
    output logic [ROB_ID_WIDTH-1:0] rd_rob_id_out,
    output logic [31:0]             stall_cycles
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_WIDTH;
    localparam logic [QUEUE_DEPTH_WIDTH:0]   FULL_COUNT = (QUEUE_DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [QUEUE_DEPTH_WIDTH-1:0] PTR_ONE    = QUEUE_DEPTH_WIDTH'(1);
    localparam logic [QUEUE_DEPTH_WIDTH:0]   CNT_ONE    = (QUEUE_DEPTH_WIDTH+1)'(1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic        pred_mem  [DEPTH];

    logic [QUEUE_DEPTH_WIDTH-1:0] head_q, head_d;
    logic [QUEUE_DEPTH_WIDTH-1:0] tail_q, tail_d;
    logic [QUEUE_DEPTH_WIDTH:0]   count_q, count_d;
    logic [31:0]                  stall_q, stall_d;

    logic [31:0] head_instr;
    logic [6:0]  opc;
    logic        legal;
    logic        has_rs1;
    logic        has_rs2;
    logic        has_rd;
    logic        to_lsb;
    logic        blocked;
    logic        not_empty;
    logic        push;
    logic        pop;
    logic        do_issue;
    logic [31:0] imm;

    assign head_instr = instr_mem[head_q];
    assign opc        = head_instr[6:0];
    assign not_empty  = (count_q != '0);
    assign queue_full = (count_q == FULL_COUNT);

    always_comb begin
        legal   = 1'b1;
        has_rs1 = 1'b1;
        has_rs2 = 1'b0;
        has_rd  = (head_instr[11:7] != 5'd0);
        imm     = 32'd0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                imm     = {head_instr[31:12], 12'd0};
                has_rs1 = 1'b0;
            end
            OPC_JAL: begin
                imm     = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20],
                           head_instr[30:21], 1'b0};
                has_rs1 = 1'b0;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                imm = {{20{head_instr[31]}}, head_instr[31:20]};
            end
            OPC_BRANCH: begin
                imm     = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25],
                           head_instr[11:8], 1'b0};
                has_rs2 = 1'b1;
                has_rd  = 1'b0;
            end
            OPC_STORE: begin
                imm     = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
                has_rs2 = 1'b1;
                has_rd  = 1'b0;
            end
            OPC_OP: begin
                has_rs2 = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign to_lsb  = (opc == OPC_LOAD) || (opc == OPC_STORE);
    assign blocked = rob_full || (to_lsb ? lsb_full : rs_full);

    assign do_issue = rdy && !rst && !flush && not_empty && legal && !blocked;
    // Illegal opcodes are dropped from the head without being issued.
    assign pop  = do_issue || (rdy && !rst && !flush && not_empty && !legal);
    assign push = fetch_valid && !queue_full && !flush && rdy;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stall_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (rdy && not_empty && legal && blocked && (stall_q != 32'hFFFF_FFFF)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Payload storage needs no reset; count gates every use of it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem[tail_q] <= fetch_instr;
            pc_mem[tail_q]    <= fetch_pc;
            pred_mem[tail_q]  <= fetch_pred_taken;
        end
    end

    assign issue_valid      = do_issue;
    assign issue_to_lsb     = to_lsb;
    assign issue_instr      = head_instr;
    assign issue_pc         = pc_mem[head_q];
    assign issue_pred_taken = pred_mem[head_q];
    assign issue_op         = head_instr[14:12];
    assign issue_type       = opc;
    assign issue_imm        = imm;
    assign issue_rd         = has_rd ? head_instr[11:7] : 5'd0;
    assign reg_id1          = head_instr[19:15];
    assign reg_id2          = head_instr[24:20];

    assign reg_value1_out = reg_value1_in;
    assign reg_value2_out = reg_value2_in;
    assign v_rob_id1_out  = v_rob_id1_in;
    assign v_rob_id2_out  = v_rob_id2_in;
    assign has_dep1_out   = has_dep1_in && has_rs1;
    assign has_dep2_out   = has_dep2_in && has_rs2;
    assign rd_rob_id_out  = has_rd ? rd_rob_id_in : '0;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: one task per scenario, inline comparisons
// against hand-computed values.
module tb_decode_issue_queue;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        fetch_valid, fetch_pred_taken;
    logic [31:0] fetch_instr, fetch_pc;
    logic        queue_full, flush, rob_full, rs_full, lsb_full;
    logic        issue_valid, issue_to_lsb, issue_pred_taken;
    logic [31:0] issue_instr, issue_pc, issue_imm;
    logic [2:0]  issue_op;
    logic [6:0]  issue_type;
    logic [4:0]  issue_rd, reg_id1, reg_id2;
    logic [31:0] reg_value1_in, reg_value2_in, reg_value1_out, reg_value2_out;
    logic        has_dep1_in, has_dep2_in, has_dep1_out, has_dep2_out;
    logic [3:0]  v_rob_id1_in, v_rob_id2_in, rd_rob_id_in;
    logic [3:0]  v_rob_id1_out, v_rob_id2_out, rd_rob_id_out;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    decode_issue_queue #(.QUEUE_DEPTH_WIDTH(3), .ROB_ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken), .queue_full(queue_full), .flush(flush),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .issue_valid(issue_valid), .issue_to_lsb(issue_to_lsb), .issue_instr(issue_instr),
        .issue_pc(issue_pc), .issue_op(issue_op), .issue_type(issue_type),
        .issue_imm(issue_imm), .issue_rd(issue_rd), .issue_pred_taken(issue_pred_taken),
        .reg_id1(reg_id1), .reg_id2(reg_id2),
        .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
        .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
        .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in), .rd_rob_id_in(rd_rob_id_in),
        .reg_value1_out(reg_value1_out), .reg_value2_out(reg_value2_out),
        .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
        .v_rob_id1_out(v_rob_id1_out), .v_rob_id2_out(v_rob_id2_out),
        .rd_rob_id_out(rd_rob_id_out), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // ADDI x<n>, x0, <n>
    function automatic logic [31:0] mk_addi(input int n);
        logic [31:0] v;
        v = (32'(n) << 20) | (32'(n) << 7) | 32'h0000_0013;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; fetch_valid = 1'b0; fetch_instr = 32'd0; fetch_pc = 32'd0;
        fetch_pred_taken = 1'b0; flush = 1'b0; rob_full = 1'b0; rs_full = 1'b0;
        lsb_full = 1'b0; reg_value1_in = 32'h1111_1111; reg_value2_in = 32'h2222_2222;
        has_dep1_in = 1'b0; has_dep2_in = 1'b0; v_rob_id1_in = 4'h3; v_rob_id2_in = 4'h6;
        rd_rob_id_in = 4'hA;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        fetch_valid = 1'b1; fetch_instr = mk_addi(1);
        tick(); tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
        checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL reset_queue_full: got %b expected 0", queue_full); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
        rst = 1'b0; fetch_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_empty_after: got %b expected 0", issue_valid); end
    endtask

    task automatic test_addi();
        do_reset();
        fetch_valid = 1'b1; fetch_instr = 32'hFFF0_8293; fetch_pc = 32'h100;
        fetch_pred_taken = 1'b1; has_dep1_in = 1'b1; has_dep2_in = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL addi_latency: got %b expected 0", issue_valid); end
        tick();
        fetch_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", issue_valid); end
        checks++; if (issue_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %h expected ffffffff", issue_imm); end
        checks++; if (issue_rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d expected 5", issue_rd); end
        checks++; if (issue_to_lsb !== 1'b0) begin errors++; $display("FAIL addi_to_lsb: got %b expected 0", issue_to_lsb); end
        checks++; if (has_dep2_out !== 1'b0) begin errors++; $display("FAIL addi_dep2: got %b expected 0", has_dep2_out); end
        checks++; if (has_dep1_out !== 1'b1) begin errors++; $display("FAIL addi_dep1: got %b expected 1", has_dep1_out); end
        checks++; if (issue_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h expected 100", issue_pc); end
        checks++; if (issue_pred_taken !== 1'b1) begin errors++; $display("FAIL addi_pred: got %b expected 1", issue_pred_taken); end
        checks++; if (rd_rob_id_out !== 4'hA) begin errors++; $display("FAIL addi_rd_rob: got %h expected a", rd_rob_id_out); end
        checks++; if (reg_id1 !== 5'd1) begin errors++; $display("FAIL addi_reg_id1: got %0d expected 1", reg_id1); end
        checks++; if (issue_op !== 3'd0) begin errors++; $display("FAIL addi_op: got %0d expected 0", issue_op); end
        tick();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL addi_popped: got %b expected 0", issue_valid); end
    endtask

    task automatic test_store_stall();
        do_reset();
        lsb_full = 1'b1; has_dep2_in = 1'b1;
        fetch_valid = 1'b1; fetch_instr = 32'h0021_A423; fetch_pc = 32'h104;
        tick();
        fetch_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL store_blocked_%0d: got %b expected 0", c, issue_valid); end
            tick();
        end
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL store_stall: got %0d expected 3", stall_cycles); end
        lsb_full = 1'b0; rs_full = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL store_valid: got %b expected 1", issue_valid); end
        checks++; if (issue_to_lsb !== 1'b1) begin errors++; $display("FAIL store_to_lsb: got %b expected 1", issue_to_lsb); end
        checks++; if (issue_rd !== 5'd0) begin errors++; $display("FAIL store_rd: got %0d expected 0", issue_rd); end
        checks++; if (rd_rob_id_out !== 4'h0) begin errors++; $display("FAIL store_rd_rob: got %h expected 0", rd_rob_id_out); end
        checks++; if (issue_imm !== 32'd8) begin errors++; $display("FAIL store_imm: got %h expected 8", issue_imm); end
        checks++; if (has_dep2_out !== 1'b1) begin errors++; $display("FAIL store_dep2: got %b expected 1", has_dep2_out); end
        tick();
        rs_full = 1'b0;
    endtask

    task automatic test_full_wrap();
        do_reset();
        rob_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fetch_valid = 1'b1; fetch_instr = mk_addi(i + 1);
            #1;
            checks++; if (queue_full !== (i == 8)) begin errors++; $display("FAIL full_fill_%0d: got %b expected %b", i, queue_full, (i == 8)); end
            tick();
        end
        checks++; if (stall_cycles !== 32'd8) begin errors++; $display("FAIL full_stall: got %0d expected 8", stall_cycles); end
        rob_full = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_%0d: got %b expected 1", k, issue_valid); end
            checks++; if (issue_rd !== 5'(k + 1)) begin errors++; $display("FAIL wrap_order_%0d: got %0d expected %0d", k, issue_rd, k + 1); end
            if (k == 0) begin
                checks++; if (queue_full !== 1'b1) begin errors++; $display("FAIL wrap_still_full: got %b expected 1", queue_full); end
            end
            if (k == 1) begin
                checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL wrap_full_drop: got %b expected 0", queue_full); end
            end
            tick();
            if (k == 1) fetch_valid = 1'b0;
        end
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained: got %b expected 0", issue_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_valid = 1'b1; fetch_instr = mk_addi(i + 1);
            tick();
        end
        checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL flush_pre_stall: got %0d expected 4", stall_cycles); end
        rob_full = 1'b0; flush = 1'b1; fetch_instr = mk_addi(20);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %b expected 0", issue_valid); end
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", issue_valid); end
        checks++; if (queue_full !== 1'b0) begin errors++; $display("FAIL flush_full: got %b expected 0", queue_full); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL flush_stall: got %0d expected 0", stall_cycles); end
        tick();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_push_lost: got %b expected 0", issue_valid); end
    endtask

    task automatic test_imm_formats();
        do_reset();
        has_dep1_in = 1'b1; has_dep2_in = 1'b1;
        fetch_valid = 1'b1; fetch_instr = 32'h1234_53B7;
        tick();
        fetch_instr = 32'h0000_0013;
        #1;
        checks++; if (issue_imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm: got %h expected 12345000", issue_imm); end
        checks++; if (has_dep1_out !== 1'b0) begin errors++; $display("FAIL lui_dep1: got %b expected 0", has_dep1_out); end
        checks++; if (issue_rd !== 5'd7) begin errors++; $display("FAIL lui_rd: got %0d expected 7", issue_rd); end
        checks++; if (issue_type !== 7'h37) begin errors++; $display("FAIL lui_type: got %h expected 37", issue_type); end
        tick();
        fetch_instr = 32'h0080_00EF;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL nop_valid: got %b expected 1", issue_valid); end
        checks++; if (issue_rd !== 5'd0) begin errors++; $display("FAIL nop_rd: got %0d expected 0", issue_rd); end
        checks++; if (rd_rob_id_out !== 4'h0) begin errors++; $display("FAIL nop_rd_rob: got %h expected 0", rd_rob_id_out); end
        checks++; if (has_dep1_out !== 1'b1) begin errors++; $display("FAIL nop_dep1: got %b expected 1", has_dep1_out); end
        tick();
        fetch_instr = 32'h0020_9863;
        #1;
        checks++; if (issue_imm !== 32'd8) begin errors++; $display("FAIL jal_imm: got %h expected 8", issue_imm); end
        checks++; if (issue_rd !== 5'd1) begin errors++; $display("FAIL jal_rd: got %0d expected 1", issue_rd); end
        checks++; if (has_dep1_out !== 1'b0) begin errors++; $display("FAIL jal_dep1: got %b expected 0", has_dep1_out); end
        tick();
        fetch_instr = 32'hFFFF_FFFF;
        #1;
        checks++; if (issue_imm !== 32'h10) begin errors++; $display("FAIL bne_imm: got %h expected 10", issue_imm); end
        checks++; if (issue_rd !== 5'd0) begin errors++; $display("FAIL bne_rd: got %0d expected 0", issue_rd); end
        checks++; if (has_dep2_out !== 1'b1) begin errors++; $display("FAIL bne_dep2: got %b expected 1", has_dep2_out); end
        checks++; if (issue_op !== 3'd1) begin errors++; $display("FAIL bne_op: got %0d expected 1", issue_op); end
        tick();
        fetch_instr = mk_addi(3);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_issue: got %b expected 0", issue_valid); end
        tick();
        fetch_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL illegal_skipped_valid: got %b expected 1", issue_valid); end
        checks++; if (issue_rd !== 5'd3) begin errors++; $display("FAIL illegal_skipped_rd: got %0d expected 3", issue_rd); end
        tick();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL imm_drained: got %b expected 0", issue_valid); end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1; fetch_instr = mk_addi(i + 1);
            tick();
        end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL rdy_pre_stall: got %0d expected 2", stall_cycles); end
        rdy = 1'b0; fetch_instr = mk_addi(9);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rdy_low_%0d: got %b expected 0", c, issue_valid); end
            tick();
        end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL rdy_stall_held: got %0d expected 2", stall_cycles); end
        rdy = 1'b1; rob_full = 1'b0; fetch_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL rdy_resume_valid_%0d: got %b expected 1", k, issue_valid); end
            checks++; if (issue_rd !== 5'(k + 1)) begin errors++; $display("FAIL rdy_resume_rd_%0d: got %0d expected %0d", k, issue_rd, k + 1); end
            tick();
        end
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rdy_no_push: got %b expected 0", issue_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_stall();
        test_full_wrap();
        test_flush();
        test_imm_formats();
        test_rdy_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
Parametrised decode stage with a buffer in front of it. It sits between Fetcher and the RS/LSB/RoB issue ports. Fetched instructions are buffered in a circular queue, decoded at the head, and issued one per cycle when the target structures have room. Unlike the previous unbuffered decoder, it also:
- masks operand dependencies per format,
- routes each instruction to RS or LSB,
- handles flushes,
- counts stall cycles.

Parameters:
QUEUE_DEPTH_WIDTH, 3, log2 of queue entries (8 entries by default)
ROB_ID_WIDTH, 4, width of RoB tags

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state is held and issue_valid=0
fetch_valid  in  1  Fetcher presents an instruction
fetch_instr  in  32  instruction word
fetch_pc  in  32  instruction address
fetch_pred_taken  in  1  predictor decision for this instruction
queue_full  out  1  queue cannot accept; Fetcher holds its data
flush  in  1  RoB mispredict/clear
rob_full  in  1  RoB has no free entry
rs_full  in  1  RS has no free entry
lsb_full  in  1  LSB has no free entry
issue_valid  out  1  head instruction is issued this cycle
issue_to_lsb  out  1  1 means LSB target; 0 means RS target (RoB always receives)
issue_instr  out  32  raw instruction
issue_pc  out  32  instruction address
issue_op  out  3  funct3
issue_type  out  7  opcode
issue_imm  out  32  decoded immediate
issue_rd  out  5  destination register, 0 if none
issue_pred_taken  out  1  stored predictor bit
reg_id1  out  5  rs1 index to Reg
reg_id2  out  5  rs2 index to Reg
reg_value1_in  in  32  rs1 value from Reg
reg_value2_in  in  32  rs2 value from Reg
has_dep1_in  in  1  rs1 dependency flag from Reg
has_dep2_in  in  1  rs2 dependency flag from Reg
v_rob_id1_in  in  ROB_ID_WIDTH  rs1 tag from Reg
v_rob_id2_in  in  ROB_ID_WIDTH  rs2 tag from Reg
rd_rob_id_in  in  ROB_ID_WIDTH  RoB tag allocated for this instruction
reg_value1_out  out  32  rs1 value
reg_value2_out  out  32  rs2 value
has_dep1_out  out  1  masked rs1 dependency
has_dep2_out  out  1  masked rs2 dependency
v_rob_id1_out  out  ROB_ID_WIDTH  rs1 tag
v_rob_id2_out  out  ROB_ID_WIDTH  rs2 tag
rd_rob_id_out  out  ROB_ID_WIDTH  destination tag, 0 if no rd
stall_cycles  out  32  count of blocked cycles

Behaviour:
Queue storage and reset
- Circular buffer of DEPTH=2^QUEUE_DEPTH_WIDTH entries, each holding {instr, pc, pred_taken}.
- State is head, tail and count, with count QUEUE_DEPTH_WIDTH+1 bits wide.
- Reset or flush (synchronous, same effect): head=tail=count=0 and stall_cycles=0.
- While rst is high: issue_valid=0, and all other outputs are combinational from the (invalid) head.

Push and full
- queue_full = (count==DEPTH), computed from registered count only; there is no bypass for a same-cycle pop.
- Push occurs when fetch_valid && !queue_full && !flush && rdy. The entry is written at tail and tail wraps modulo DEPTH.
- A pushed entry is issuable in the next cycle at the earliest (1-cycle latency).

Head decode (combinational)
- issue_op = instr[14:12]; issue_type = instr[6:0]; reg_id1 = instr[19:15]; reg_id2 = instr[24:20].
- issue_imm by opcode:
  - LUI/AUIPC: U-immediate.
  - JAL: J-immediate.
  - JALR, loads, I-type ALU: sign-extended I-immediate.
  - Branches: B-immediate.
  - Stores: S-immediate.
  - R-type and anything else: 0.
- has_rs1 = not (LUI, AUIPC, JAL).
- has_rs2 = R-type, store or branch.
- has_rd = not (branch, store) and instr[11:7]!=0.
- has_dep1_out = has_dep1_in && has_rs1; has_dep2_out = has_dep2_in && has_rs2.
- issue_rd = has_rd ? instr[11:7] : 0.
- rd_rob_id_out = has_rd ? rd_rob_id_in : 0.
- Values and tags pass straight through from Reg.
- issue_to_lsb = load or store opcode.

Issue and pop
- blocked = rob_full || (issue_to_lsb ? lsb_full : rs_full).
- issue_valid = rdy && !rst && !flush && count!=0 && legal && !blocked.
- Pop (head++ with wrap) happens when issue_valid is high.
- An illegal (unknown) opcode at head is popped without issue: issue_valid=0 for that cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- count is always within 0..DEPTH.

Stall counter
- stall_cycles increments when rdy && !flush && count!=0 && legal && blocked.
- It saturates at 0xFFFFFFFF.

Flush
- Flush dominates push and pop in the same cycle.
- The queue is empty from the next cycle onward.

Test Plan:
1. Reset, then push ADDI x5,x1,-1 (0xFFF08293) at pc 0x100 with all full flags low → next cycle: issue_valid=1, issue_imm=0xFFFFFFFF, issue_rd=5, issue_to_lsb=0, has_dep2_out=0 even with has_dep2_in=1.
2. Push SW x2,8(x3) (0x0021A423) with lsb_full=1 for 3 cycles → issue_valid=0 for 3 cycles and stall_cycles=3; then lsb_full=0 → issue_valid=1, issue_to_lsb=1, issue_rd=0, rd_rob_id_out=0.
3. Hold rob_full=1 and push 9 consecutive instructions → queue_full=1 after the 8th accept and the 9th is held; release rob_full → 8 issues in order across pointer wrap, and the 9th is accepted the cycle after full drops.
4. Queue holds 5 entries and flush=1 coincides with fetch_valid=1 → the following cycle count=0, issue_valid=0, queue_full=0, and the pushed instruction is lost.
5. LUI x7,0x12345 (0x123453B7) with has_dep1_in=1 → issue_imm=0x12345000 and has_dep1_out=0; ADDI x0,x0,0 → issue_rd=0 and rd_rob_id_out=0.
6. Drive rdy=0 mid-stream with 3 entries queued → no push, no pop, issue_valid=0, stall_cycles unchanged; rdy=1 → issue resumes from the same head.
